rpn_stack_calc: RTL and testbench

- Parametrised reverse-polish calculator core, successor to the fixed two-operand calculator top.
- Replaces the OpA/OpB/OpCode sequencing FSM with a DEPTH-entry operand stack of N-bit words. Adds one-level undo of pushes and operations, and stack overflow/underflow error reporting.
- Sits between the board switch/button inputs and the 7-segment display driver.

---
 rtl/rpn_calc_pkg.sv | 125 ++++++++++++
 rtl/rpn_edge_pulse.sv | 26 ++
 rtl/rpn_stack_calc.sv | 201 ++++++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_calc_pkg.sv
// Shared types, index constants and the ALU function for the RPN calculator core.
package rpn_calc_pkg;

    // Internal ALU datapath width; operands narrower than this are zero-extended.
    localparam int ALU_W = 64;

    // Bit positions inside the 4-bit {N,Z,C,V} flag word.
    localparam int FLG_V = 0;
    localparam int FLG_C = 1;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 3;

    // Bit positions inside the 2-bit {overflow, underflow} error word.
    localparam int ERR_UNF = 0;
    localparam int ERR_OVF = 1;

    typedef enum logic [2:0] {
        OPC_ADD  = 3'd0,
        OPC_SUB  = 3'd1,
        OPC_AND  = 3'd2,
        OPC_OR   = 3'd3,
        OPC_XOR  = 3'd4,
        OPC_NAND = 3'd5,
        OPC_SHL  = 3'd6,
        OPC_SHR  = 3'd7
    } opcode_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        HIST_NONE = 2'd0,
        HIST_PUSH = 2'd1,
        HIST_OP   = 2'd2
    } hist_t;

    typedef logic [ALU_W-1:0] word_t;

    typedef struct packed {
        word_t      res;
        logic [3:0] flags;
    } alu_out_t;

    // Width-generic ALU: a and b hold 'width'-bit values zero-extended to ALU_W.
    // 'shw' is the number of low bits of b used as the shift amount.
    // Flag bits are located with masks rather than variable indices so the
    // same function serves every operand width up to ALU_W.
    function automatic alu_out_t alu_eval(input opcode_t     op,
                                          input word_t       a,
                                          input word_t       b,
                                          input int unsigned width,
                                          input int unsigned shw);
        alu_out_t             out;
        word_t                mask;
        word_t                msb;
        word_t                sh;
        word_t                res;
        word_t                add_res;
        word_t                sub_res;
        logic [ALU_W:0]       sum_add;
        logic [2*ALU_W-1:0]   shl_ext;
        logic [ALU_W:0]       shr_ext;
        logic                 sa;
        logic                 sb;
        logic                 add_v;
        logic                 sub_v;
        logic                 c;
        logic                 v;
        mask    = (64'd1 << width) - 64'd1;
        msb     = 64'd1 << (width - 1);
        sh      = b & ((64'd1 << shw) - 64'd1);
        sa      = |(a & msb);
        sb      = |(b & msb);
        sum_add = {1'b0, a} + {1'b0, b};
        add_res = sum_add[ALU_W-1:0] & mask;
        sub_res = (a - b) & mask;
        add_v   = (sa == sb) && ((|(add_res & msb)) != sa);
        sub_v   = (sa != sb) && ((|(sub_res & msb)) != sa);
        shl_ext = {64'd0, a} << sh;
        shr_ext = {a, 1'b0} >> sh;
        res     = 64'd0;
        c       = 1'b0;
        v       = 1'b0;
        case (op)
            OPC_ADD: begin
                res = add_res;
                c   = |(sum_add & (65'd1 << width));
                v   = add_v;
            end
            OPC_SUB: begin
                res = sub_res;
                c   = (a < b);
                v   = sub_v;
            end
            OPC_AND:  res = a & b;
            OPC_OR:   res = a | b;
            OPC_XOR:  res = a ^ b;
            OPC_NAND: res = ~(a & b) & mask;
            OPC_SHL: begin
                // The last bit pushed out lands just above the result field.
                res = shl_ext[ALU_W-1:0] & mask;
                c   = |(shl_ext & (128'd1 << width));
            end
            OPC_SHR: begin
                // A guard bit below the LSB catches the last bit shifted out.
                res = shr_ext[ALU_W:1];
                c   = shr_ext[0];
            end
            default: begin
                res = 64'd0;
                c   = 1'b0;
                v   = 1'b0;
            end
        endcase
        out.res          = res;
        out.flags[FLG_N] = |(res & msb);
        out.flags[FLG_Z] = (res == 64'd0);
        out.flags[FLG_C] = c;
        out.flags[FLG_V] = v;
        return out;
    endfunction

endpackage

// File: rtl/rpn_edge_pulse.sv
// Level-to-pulse converter for a button input: one-cycle pulse in the cycle
// following the clock edge that first samples the level high.
module rpn_edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic sample_r;
    logic prev_r;

    // Sample the button level and keep the previous sample for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_r <= 1'b0;
            prev_r   <= 1'b0;
        end else begin
            sample_r <= level;
            prev_r   <= sample_r;
        end
    end

    assign pulse = sample_r & ~prev_r;

endmodule

// File: rtl/rpn_stack_calc.sv
// Reverse-polish calculator core: DEPTH-entry operand stack, eight ALU
// operations, one-level undo and sticky overflow/underflow reporting.
// Operand width N is limited to the package ALU width (64 bits).
module rpn_stack_calc
    import rpn_calc_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enter,
    input  logic                       undo,
    input  logic                       op_sel,
    input  logic [N-1:0]               data_in,
    output logic [N-1:0]               to_display,
    output logic [3:0]                 flags,
    output logic [1:0]                 err,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       busy
);

    localparam int          DW  = $clog2(DEPTH + 1);
    localparam int          AW  = $clog2(DEPTH);
    localparam int unsigned SHW = $clog2(N);

    typedef logic [N-1:0] data_t;

    data_t            stack_r [DEPTH];
    logic [DW-1:0]    depth_r;
    logic [3:0]       flags_r;
    logic [1:0]       err_r;
    state_t           state_r;
    state_t           state_next_s;
    opcode_t          op_r;
    hist_t            hist_r;
    data_t            hist_a_r;
    data_t            hist_b_r;
    logic [3:0]       hist_flags_r;

    logic             enter_pulse_s;
    logic             undo_pulse_s;
    logic             push_go_s;
    logic             push_fail_s;
    logic             op_go_s;
    logic             op_fail_s;
    logic             undo_go_s;
    logic             exec_go_s;

    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    below_idx_s;
    logic [AW-1:0]    push_idx_s;
    data_t            opnd_a_s;
    data_t            opnd_b_s;
    alu_out_t         alu_out_s;

    rpn_edge_pulse u_enter_pulse (
        .clk   (clk),
        .reset (reset),
        .level (enter),
        .pulse (enter_pulse_s)
    );

    rpn_edge_pulse u_undo_pulse (
        .clk   (clk),
        .reset (reset),
        .level (undo),
        .pulse (undo_pulse_s)
    );

    assign top_idx_s   = AW'(depth_r - DW'(1));
    assign below_idx_s = AW'(depth_r - DW'(2));
    assign push_idx_s  = AW'(depth_r);
    assign opnd_a_s    = stack_r[below_idx_s];
    assign opnd_b_s    = stack_r[top_idx_s];
    assign alu_out_s   = alu_eval(op_r, word_t'(opnd_a_s), word_t'(opnd_b_s), N, SHW);

    // Decode button pulses into one action strobe and pick the next FSM state.
    always_comb begin
        state_next_s = state_r;
        push_go_s    = 1'b0;
        push_fail_s  = 1'b0;
        op_go_s      = 1'b0;
        op_fail_s    = 1'b0;
        undo_go_s    = 1'b0;
        exec_go_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (undo_pulse_s) begin
                    // Undo has priority; a simultaneous enter is dropped.
                    undo_go_s = (hist_r != HIST_NONE);
                end else if (enter_pulse_s) begin
                    if (!op_sel) begin
                        if (depth_r == DW'(DEPTH)) begin
                            push_fail_s = 1'b1;
                        end else begin
                            push_go_s = 1'b1;
                        end
                    end else begin
                        if (depth_r >= DW'(2)) begin
                            op_go_s      = 1'b1;
                            state_next_s = ST_EXEC;
                        end else begin
                            op_fail_s = 1'b1;
                        end
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Pulses seen here are ignored.
                exec_go_s    = 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Stack, flags, error and undo-history updates for each committed action.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {N{1'b0}};
            end
            depth_r      <= {DW{1'b0}};
            flags_r      <= 4'b0000;
            err_r        <= 2'b00;
            op_r         <= OPC_ADD;
            hist_r       <= HIST_NONE;
            hist_a_r     <= {N{1'b0}};
            hist_b_r     <= {N{1'b0}};
            hist_flags_r <= 4'b0000;
        end else if (push_go_s) begin
            stack_r[push_idx_s] <= data_in;
            depth_r             <= depth_r + DW'(1);
            err_r               <= 2'b00;
            hist_r              <= HIST_PUSH;
        end else if (push_fail_s) begin
            err_r[ERR_OVF] <= 1'b1;
        end else if (op_go_s) begin
            op_r <= opcode_t'(data_in[2:0]);
        end else if (op_fail_s) begin
            err_r[ERR_UNF] <= 1'b1;
        end else if (undo_go_s) begin
            if (hist_r == HIST_OP) begin
                // Result slot gets A back, B goes one above it.
                stack_r[top_idx_s]  <= hist_a_r;
                stack_r[push_idx_s] <= hist_b_r;
                depth_r             <= depth_r + DW'(1);
                flags_r             <= hist_flags_r;
            end else begin
                depth_r <= depth_r - DW'(1);
            end
            err_r  <= 2'b00;
            hist_r <= HIST_NONE;
        end else if (exec_go_s) begin
            stack_r[below_idx_s] <= data_t'(alu_out_s.res);
            depth_r              <= depth_r - DW'(1);
            flags_r              <= alu_out_s.flags;
            err_r                <= 2'b00;
            hist_r               <= HIST_OP;
            hist_a_r             <= opnd_a_s;
            hist_b_r             <= opnd_b_s;
            hist_flags_r         <= flags_r;
        end else begin
            depth_r <= depth_r;
        end
    end

    // Display mux: stack top in operation mode, raw switches otherwise.
    always_comb begin
        to_display = data_in;
        if (op_sel) begin
            if (depth_r == {DW{1'b0}}) begin
                to_display = {N{1'b0}};
            end else begin
                to_display = stack_r[top_idx_s];
            end
        end else begin
            to_display = data_in;
        end
    end

    assign depth = depth_r;
    assign flags = flags_r;
    assign err   = err_r;
    assign busy  = (state_r == ST_EXEC);

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Self-checking bench for rpn_stack_calc (N=16, DEPTH=4): directed scenarios
// followed by random push/operate/undo traffic checked against a queue model.
module tb_rpn_stack_calc;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          enter;
    logic          undo;
    logic          op_sel;
    logic [N-1:0]  data_in;
    logic [N-1:0]  to_display;
    logic [3:0]    flags;
    logic [1:0]    err;
    logic [2:0]    depth;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic [3:0]  mflags;
    logic [1:0]  merr;
    int          mhist;      // 0 none, 1 push, 2 op
    logic [15:0] ha, hb;
    logic [3:0]  hf;

    rpn_stack_calc #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enter      (enter),
        .undo       (undo),
        .op_sel     (op_sel),
        .data_in    (data_in),
        .to_display (to_display),
        .flags      (flags),
        .err        (err),
        .depth      (depth),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_alu(input int op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output logic [3:0] f);
        int unsigned ua, ub, s, sh;
        logic c, v;
        ua = a; ub = b; sh = ub % 16; c = 1'b0; v = 1'b0; r = 16'h0;
        case (op)
            0: begin s = ua + ub; r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
            1: begin r = a - b; c = (ua < ub); v = (a[15] != b[15]) && (r[15] != a[15]); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = ~(a & b);
            6: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[16 - sh]; end
            7: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
            default: r = 16'h0;
        endcase
        f = {r[15], (r == 16'h0), c, v};
    endfunction

    task automatic model_reset();
        mq.delete(); mflags = 4'h0; merr = 2'b00; mhist = 0;
    endtask

    task automatic model_push(input logic [15:0] d);
        if (mq.size() == DEPTH) merr[1] = 1'b1;
        else begin mq.push_back(d); merr = 2'b00; mhist = 1; end
    endtask

    task automatic model_op(input int opc);
        logic [15:0] a, b, r;
        logic [3:0] f;
        if (mq.size() < 2) merr[0] = 1'b1;
        else begin
            b = mq.pop_back(); a = mq.pop_back();
            model_alu(opc, a, b, r, f);
            mq.push_back(r);
            ha = a; hb = b; hf = mflags;
            mflags = f; merr = 2'b00; mhist = 2;
        end
    endtask

    task automatic model_undo();
        logic [15:0] tmp;
        if (mhist == 1) begin
            tmp = mq.pop_back(); merr = 2'b00; mhist = 0;
        end else if (mhist == 2) begin
            tmp = mq.pop_back(); mq.push_back(ha); mq.push_back(hb);
            mflags = hf; merr = 2'b00; mhist = 0;
        end
    endtask

    task automatic check_state(input string tag);
        logic [15:0] exp_top;
        if (mq.size() == 0) exp_top = 16'h0; else exp_top = mq[$];
        op_sel = 1'b1;
        #1;
        check({tag, ".top"}, to_display, exp_top);
        op_sel  = 1'b0;
        data_in = 16'($urandom);
        #1;
        check({tag, ".disp"}, to_display, data_in);
        check({tag, ".depth"}, depth, mq.size());
        check({tag, ".flags"}, flags, mflags);
        check({tag, ".err"}, err, merr);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; enter = 1'b0; undo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One button action; optional undo press during EXEC or reset during EXEC.
    task automatic press(input logic e, input logic u, input logic os, input logic [15:0] d,
                         input bit undo_in_exec, input bit reset_in_exec);
        logic exec_exp;
        exec_exp = e && !u && os && (mq.size() >= 2);
        op_sel = os; data_in = d; enter = e; undo = u;
        @(posedge clk); #1;
        check("busy_pulse", busy, 1'b0);
        if (undo_in_exec) undo = 1'b1;
        @(posedge clk); #1;
        check("busy_exec", busy, exec_exp);
        if (reset_in_exec) begin reset = 1'b1; enter = 1'b0; undo = 1'b0; end
        @(posedge clk); #1;
        reset = 1'b0; enter = 1'b0; undo = 1'b0;
        check("busy_done", busy, 1'b0);
        if (reset_in_exec) begin
            check("rst_exec.depth", depth, 3'd0);
            check("rst_exec.flags", flags, 4'h0);
            model_reset();
        end else if (u) model_undo();
        else if (e && os) model_op(int'(d[2:0]));
        else if (e) model_push(d);
        repeat (2) @(posedge clk);
        #1;
        check_state("act");
    endtask

    task automatic push(input logic [15:0] d);
        press(1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic oper(input int opc);
        press(1'b1, 1'b0, 1'b1, {13'($urandom), 3'(opc)}, 1'b0, 1'b0);
    endtask

    task automatic undo_press();
        press(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; enter = 1'b0; undo = 1'b0; op_sel = 1'b0; data_in = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_state("reset");

        // 5 - 3
        push(16'd5); push(16'd3); oper(1);
        check("sub1.top", mq[$], 16'd2);
        check("sub1.flags", flags, 4'b0000);
        check("sub1.depth", depth, 3'd1);

        // 3 - 5 borrows
        do_reset();
        push(16'd3); push(16'd5); oper(1);
        check("sub2.flags", flags, 4'b1010);

        // 0x7FFF + 1 overflows, then undo twice, then SUB to expose A
        do_reset();
        push(16'h7FFF); push(16'd1); oper(0);
        check("add.flags", flags, 4'b1001);
        check("add.depth", depth, 3'd1);
        undo_press();
        check("undo_op.depth", depth, 3'd2);
        check("undo_op.flags", flags, 4'b0000);
        undo_press();
        check("undo2.depth", depth, 3'd2);
        oper(1);
        op_sel = 1'b1; #1;
        check("undo_op.a_restored", to_display, 16'h7FFE);

        // Overflow of a full stack, then undo clears err
        do_reset();
        for (int i = 1; i <= 5; i++) push(16'(i));
        check("ovf.err", err, 2'b10);
        check("ovf.depth", depth, 3'd4);
        undo_press();
        check("ovf_undo.err", err, 2'b00);
        check("ovf_undo.depth", depth, 3'd3);

        // Underflow with a single entry
        do_reset();
        push(16'd7); oper(0);
        check("unf.err", err, 2'b01);
        check("unf.depth", depth, 3'd1);

        // Enter and undo together: undo wins
        do_reset();
        push(16'd9);
        press(1'b1, 1'b1, 1'b0, 16'd11, 1'b0, 1'b0);
        check("both.depth", depth, 3'd0);

        // Undo pulse during EXEC is dropped
        do_reset();
        push(16'd6); push(16'd4);
        press(1'b1, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0);
        check("drop.depth", depth, 3'd1);

        // Reset during EXEC aborts the write
        do_reset();
        push(16'd2); push(16'd2);
        press(1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) push(16'($urandom));
            else if (r < 8) oper($urandom_range(0, 7));
            else if (r < 9) undo_press();
            else press(1'b1, 1'b1, 1'($urandom), 16'($urandom), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
